// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: depth calculation, Gray/binary conversion and
// the full-compare reference used by the write-side pointer logic.
package fifo_pkg;

    localparam int unsigned ADDR_SIZE_DFLT = 32'd4;
    localparam int unsigned DEPTH          = 32'd1 << ADDR_SIZE_DFLT;

    // Number of words addressed by an addr_size-bit address.
    function automatic int unsigned fifo_depth(input int unsigned addr_size);
        return 32'd1 << addr_size;
    endfunction

    // Binary to reflected Gray. Zero-extended inputs keep the result valid
    // for any width up to 32 bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 32'd1) ^ bin;
    endfunction

    // Gray to binary. Each binary bit is the XOR of all Gray bits at or
    // above it, so zero-extended upper bits do not disturb the result.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = 32'd0;
        for (int i = 0; i < 32; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

    // Write pointer value that means "full" for a given read pointer:
    // the read Gray pointer with its top two bits inverted.
    function automatic logic [31:0] gray_full_ref(input logic [31:0]   rgray,
                                                  input int unsigned   addr_size);
        return rgray ^ (32'd3 << (addr_size - 32'd1));
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write-side full logic and the read-side empty logic.
module fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each output bit is the XOR reduction of the Gray bits at and above it.
    always_comb begin
        bin = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag generator of the async FIFO (wclk domain).
// Produces the memory write address, the Gray write pointer for the
// read-domain synchroniser, and full / almost-full / level / overflow flags
// derived from the synchronised Gray read pointer. All outputs are registered.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int AF_THRESH = 12
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 woverflow
);

    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0] wbin_r;
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] wlevel_r;
    logic          wfull_r;
    logic          walmost_full_r;
    logic          woverflow_r;

    logic          we_s;
    logic [PW-1:0] wbin_nxt_s;
    logic [PW-1:0] wgray_nxt_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_nxt_s;
    logic [PW-1:0] full_ref_s;
    logic          full_nxt_s;
    logic          afull_nxt_s;
    logic          ovf_nxt_s;
    logic [31:0]   gray32_s;
    logic [31:0]   full_ref32_s;

    fifo_gray2bin #(.W(PW)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

    // Next pointer, Gray encoding, full/almost-full/level and overflow terms.
    always_comb begin
        we_s         = winc & ~wfull_r;
        wbin_nxt_s   = wbin_r + {{ADDR_SIZE{1'b0}}, we_s};
        gray32_s     = bin2gray(32'(wbin_nxt_s));
        wgray_nxt_s  = gray32_s[PW-1:0];
        full_ref32_s = gray_full_ref(32'(wq2_rptr), int'(ADDR_SIZE));
        full_ref_s   = full_ref32_s[PW-1:0];
        full_nxt_s   = (wgray_nxt_s == full_ref_s);
        // Modulo subtraction across the extra MSB yields 0..DEPTH directly.
        level_nxt_s  = wbin_nxt_s - rbin_s;
        afull_nxt_s  = (level_nxt_s >= PW'(AF_THRESH));
        ovf_nxt_s    = woverflow_r | (winc & wfull_r);
    end

    // Pointer and flag registers; everything returns to zero on reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_r         <= {PW{1'b0}};
            wptr_r         <= {PW{1'b0}};
            wlevel_r       <= {PW{1'b0}};
            wfull_r        <= 1'b0;
            walmost_full_r <= 1'b0;
            woverflow_r    <= 1'b0;
        end else begin
            wbin_r         <= wbin_nxt_s;
            wptr_r         <= wgray_nxt_s;
            wlevel_r       <= level_nxt_s;
            wfull_r        <= full_nxt_s;
            walmost_full_r <= afull_nxt_s;
            woverflow_r    <= ovf_nxt_s;
        end
    end

    assign waddr        = wbin_r[ADDR_SIZE-1:0];
    assign wptr         = wptr_r;
    assign wlevel       = wlevel_r;
    assign wfull        = wfull_r;
    assign walmost_full = walmost_full_r;
    assign woverflow    = woverflow_r;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (ADDR_SIZE=4, AF_THRESH=12).
module tb_fifo_wptr_full;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int n_pass;
    int n_total;

    fifo_wptr_full #(.ADDR_SIZE(4), .AF_THRESH(12)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Observed outputs packed {waddr, wptr, wfull, walmost_full, wlevel, woverflow}.
    function automatic logic [16:0] obs_vec();
        return {waddr, wptr, wfull, walmost_full, wlevel, woverflow};
    endfunction

    task automatic tick();
        @(posedge wclk);
        @(negedge wclk);
    endtask

    task automatic do_reset();
        @(negedge wclk);
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wq2_rptr = 5'd0;
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [16:0] o;
        #1;
        o = obs_vec();
        n_total++;
        if (o !== 17'd0) $display("FAIL reset_async got %h exp %h", o, 17'd0);
        else n_pass++;
        @(negedge wclk);
        wrst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = obs_vec();
            n_total++;
            if (o !== 17'd0) $display("FAIL reset_idle%0d got %h exp %h", i, o, 17'd0);
            else n_pass++;
        end
    endtask

    task automatic test_fill();
        logic [16:0] o;
        logic [16:0] e;
        for (int k = 1; k <= 16; k++) begin
            winc = 1'b1;
            tick();
            e = {4'(k % 16), 5'(k ^ (k >> 1)), (k == 16), (k >= 12), 5'(k), 1'b0};
            o = obs_vec();
            n_total++;
            if (o !== e) $display("FAIL fill_w%0d got %h exp %h", k, o, e);
            else n_pass++;
        end
        winc = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            winc = 1'b1;
            tick();
            n_total++;
            if ({wptr, waddr, wfull, woverflow, wlevel} !== {5'b11000, 4'd0, 1'b1, 1'b1, 5'd16})
                $display("FAIL overflow_c%0d got wptr=%b waddr=%0d full=%b ovf=%b lvl=%0d exp 11000/0/1/1/16",
                         i, wptr, waddr, wfull, woverflow, wlevel);
            else n_pass++;
        end
        winc = 1'b0;
        tick();
        tick();
        n_total++;
        if (woverflow !== 1'b1) $display("FAIL overflow_sticky got %b exp 1", woverflow);
        else n_pass++;
    endtask

    task automatic test_drain_view();
        wq2_rptr = 5'b00001;
        tick();
        n_total++;
        if ({wfull, wlevel, walmost_full} !== {1'b0, 5'd15, 1'b1})
            $display("FAIL drain_release got full=%b lvl=%0d af=%b exp 0/15/1", wfull, wlevel, walmost_full);
        else n_pass++;
        winc = 1'b1;
        tick();
        winc = 1'b0;
        n_total++;
        if ({wfull, wlevel, waddr, wptr, woverflow} !== {1'b1, 5'd16, 4'd1, 5'b11001, 1'b1})
            $display("FAIL drain_refill got full=%b lvl=%0d waddr=%0d wptr=%b ovf=%b exp 1/16/1/11001/1",
                     wfull, wlevel, waddr, wptr, woverflow);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        int nb;
        int rb;
        do_reset();
        winc = 1'b1;
        tick();
        tick();
        prev = wptr;
        for (int k = 2; k < 42; k++) begin
            rb       = (k - 1) % 32;
            wq2_rptr = 5'(rb ^ (rb >> 1));
            winc     = 1'b1;
            tick();
            nb = (k + 1) % 32;
            n_total++;
            if ({waddr, wptr, wfull, wlevel} !== {4'(nb % 16), 5'(nb ^ (nb >> 1)), 1'b0, 5'd2})
                $display("FAIL wrap_w%0d got waddr=%0d wptr=%b full=%b lvl=%0d exp %0d/%b/0/2",
                         k, waddr, wptr, wfull, wlevel, nb % 16, 5'(nb ^ (nb >> 1)));
            else n_pass++;
            n_total++;
            if ($countones(wptr ^ prev) !== 1)
                $display("FAIL wrap_hamming%0d got %0d exp 1", k, $countones(wptr ^ prev));
            else n_pass++;
            prev = wptr;
        end
        winc = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        winc = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        winc = 1'b0;
        n_total++;
        if ({wlevel, walmost_full} !== {5'd8, 1'b0})
            $display("FAIL simul_pre got lvl=%0d af=%b exp 8/0", wlevel, walmost_full);
        else n_pass++;
        winc     = 1'b1;
        wq2_rptr = 5'b00001;
        tick();
        winc = 1'b0;
        n_total++;
        if ({wlevel, walmost_full, waddr, wfull} !== {5'd8, 1'b0, 4'd9, 1'b0})
            $display("FAIL simul got lvl=%0d af=%b waddr=%0d full=%b exp 8/0/9/0",
                     wlevel, walmost_full, waddr, wfull);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [16:0] o;
        #2;
        wrst_n = 1'b0;
        #1;
        o = obs_vec();
        n_total++;
        if (o !== 17'd0) $display("FAIL reset_midop got %h exp %h", o, 17'd0);
        else n_pass++;
        @(negedge wclk);
        wrst_n   = 1'b1;
        wq2_rptr = 5'd0;
        tick();
        tick();
        o = obs_vec();
        n_total++;
        if (o !== 17'd0) $display("FAIL reset_midop_hold got %h exp %h", o, 17'd0);
        else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wq2_rptr = 5'd0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain_view();
        test_wrap();
        test_simultaneous();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
